// File: rtl/div_16x8_seq_pkg.sv
// Shared types and constants for the sequential 16/8 restoring divider.
// Imported by the step, interface and top-level files.
package div_pkg;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_t;

    localparam int DW    = 16;
    localparam int QW    = 8;
    localparam int STEPS = 8;

    localparam logic [QW-1:0] QSAT = 8'hFF;

endpackage

// File: rtl/div_16x8_seq_if.sv
// Request/result handshake bundle for the 16/8 divider.
// The slave modport is the divider side; the master modport is the requester side.
interface div_16x8_seq_if;
    import div_pkg::*;

    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] R;
    logic [QW-1:0] B;
    logic          out_valid;
    logic          out_ready;
    logic [QW-1:0] Q;
    logic [QW-1:0] REM;
    logic          ovf;
    logic          dz;

    modport slave (
        input  in_valid, R, B, out_ready,
        output in_ready, out_valid, Q, REM, ovf, dz
    );

    modport master (
        output in_valid, R, B, out_ready,
        input  in_ready, out_valid, Q, REM, ovf, dz
    );

endinterface

// File: rtl/div_16x8_seq_step.sv
// One combinational restoring-division step: shift the next dividend bit into the
// partial remainder and subtract the divisor when it fits.
module div_step
    import div_pkg::*;
(
    input  logic [QW:0]   i_p,
    input  logic          i_nextBit,
    input  logic [QW-1:0] i_b,
    output logic [QW:0]   o_pNext,
    output logic          o_qbit
);

    logic [QW+1:0] w_t;
    logic [QW+1:0] w_diff;

    // The partial remainder is always below B, so P[8] is zero and w_t never exceeds 2B-1.
    assign w_t     = {i_p, i_nextBit};
    assign w_diff  = w_t - {2'b00, i_b};
    assign o_qbit  = (w_t >= {2'b00, i_b});
    assign o_pNext = o_qbit ? w_diff[QW:0] : w_t[QW:0];

endmodule

// File: rtl/div_16x8_seq.sv
// Sequential radix-2 restoring divider: 16-bit dividend over 8-bit divisor, eight
// steps per request, with optional dividend LSB truncation for an approximate result.
module div_16x8_seq
    import div_pkg::*;
#(
    parameter int APPROX_LSB = 0
) (
    input  logic            clk,
    input  logic            rst,
    div_16x8_seq_if.slave   bus
);

    localparam logic [DW-1:0] TRUNC_MASK = ~((DW'(1) << APPROX_LSB) - DW'(1));

    state_t        r_state;
    state_t        w_stateNext;
    logic [QW:0]   r_p;
    logic [QW-1:0] r_qsr;
    logic [QW-1:0] r_b;
    logic [2:0]    r_cnt;
    logic [QW-1:0] r_q;
    logic [QW-1:0] r_rem;
    logic          r_ovf;
    logic          r_dz;

    logic [DW-1:0] w_rt;
    logic          w_accept;
    logic          w_special;
    logic          w_lastStep;
    logic [QW:0]   w_pNext;
    logic          w_qbit;

    assign w_rt       = bus.R & TRUNC_MASK;
    assign w_accept   = bus.in_valid && (r_state == IDLE);
    assign w_special  = (bus.B == '0) || (w_rt[DW-1:QW] >= bus.B);
    assign w_lastStep = (r_cnt == 3'(STEPS - 1));

    div_step u_step (
        .i_p       (r_p),
        .i_nextBit (r_qsr[QW-1]),
        .i_b       (r_b),
        .o_pNext   (w_pNext),
        .o_qbit    (w_qbit)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_stateNext;
        end
    end

    always_comb begin
        w_stateNext = r_state;
        case (r_state)
            IDLE:    if (w_accept) w_stateNext = w_special ? DONE : CALC;
            CALC:    if (w_lastStep) w_stateNext = DONE;
            DONE:    if (bus.out_ready) w_stateNext = IDLE;
            default: w_stateNext = IDLE;
        endcase
    end

    // Overflow and divide-by-zero resolve at accept; otherwise the quotient register
    // starts holding the low dividend byte and fills with quotient bits from the right.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_p   <= '0;
            r_qsr <= '0;
            r_b   <= '0;
            r_cnt <= '0;
            r_q   <= '0;
            r_rem <= '0;
            r_ovf <= 1'b0;
            r_dz  <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_b <= bus.B;
                        if (bus.B == '0) begin
                            r_q   <= QSAT;
                            r_rem <= QSAT;
                            r_ovf <= 1'b1;
                            r_dz  <= 1'b1;
                        end else if (w_rt[DW-1:QW] >= bus.B) begin
                            r_q   <= QSAT;
                            r_rem <= QSAT;
                            r_ovf <= 1'b1;
                            r_dz  <= 1'b0;
                        end else begin
                            r_p   <= {1'b0, w_rt[DW-1:QW]};
                            r_qsr <= w_rt[QW-1:0];
                            r_cnt <= '0;
                        end
                    end
                end
                CALC: begin
                    r_p   <= w_pNext;
                    r_qsr <= {r_qsr[QW-2:0], w_qbit};
                    r_cnt <= r_cnt + 3'd1;
                    if (w_lastStep) begin
                        r_q   <= {r_qsr[QW-2:0], w_qbit};
                        r_rem <= w_pNext[QW-1:0];
                        r_ovf <= 1'b0;
                        r_dz  <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.in_ready  = (r_state == IDLE);
    assign bus.out_valid = (r_state == DONE);
    assign bus.Q         = r_q;
    assign bus.REM       = r_rem;
    assign bus.ovf       = r_ovf;
    assign bus.dz        = r_dz;

endmodule
